reg_file_sb: RTL

Parametrised successor to the core's integer register file. It keeps two combinational read ports and one synchronous write port. It adds:
- configurable width and depth;
- a hardwired-zero register 0;
- optional write-to-read bypass;
- a per-register busy scoreboard with a pending-write counter, used by the issue stage to detect RAW hazards.

It sits between decode/issue, which reads operands and marks destinations, and writeback, which writes and clears.

---
 rtl/reg_file_sb_if.sv | 30 +++
 rtl/reg_file_sb.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reg_file_sb_if.sv
// Operand-read, writeback and issue-scoreboard signals of the register file.
// The issue/writeback side drives through master; the register file is the slave.
interface reg_file_sb_if #(
  parameter int N  = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ReadReg1;
  logic [AW-1:0] ReadReg2;
  logic [N-1:0]  Read_data1;
  logic [N-1:0]  Read_data2;
  logic          busy1;
  logic          busy2;
  logic [AW-1:0] WriteReg;
  logic          RegWrite;
  logic [N-1:0]  D;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          flush;
  logic [AW:0]   pending_count;

  modport master (
    output ReadReg1, ReadReg2, WriteReg, RegWrite, D, issue_valid, issue_rd, flush,
    input  Read_data1, Read_data2, busy1, busy2, pending_count
  );

  modport slave (
    input  ReadReg1, ReadReg2, WriteReg, RegWrite, D, issue_valid, issue_rd, flush,
    output Read_data1, Read_data2, busy1, busy2, pending_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file: two combinational read ports, one write port, optional
// write-to-read forwarding and a per-register busy scoreboard for RAW detection.
module reg_file_sb #(
  parameter int N      = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [N-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt;

  logic [IW-1:0] rd1_idx, rd2_idx, wr_idx, iss_idx;
  logic          rd1_live, rd2_live, wr_live, iss_live;
  logic          wr_en, iss_en;
  logic          fwd1, fwd2;
  logic          set_evt, clr_evt;
  logic [N-1:0]  rdata1, rdata2;
  logic          rbusy1, rbusy2;

  // Register 0 and addresses at or beyond DEPTH hold nothing.
  function automatic logic live_addr(input logic [AW-1:0] addr);
    return (addr != '0) && ({1'b0, addr} < DEPTH_A);
  endfunction

  // Net change is at most one step; the guards keep the counter from wrapping.
  function automatic logic [AW:0] count_step(input logic [AW:0] c,
                                             input logic        inc,
                                             input logic        dec);
    logic [AW:0] r;
    r = c;
    if (inc && !dec && (c < CNT_MAX))
      r = c + CNT_ONE;
    else if (dec && !inc && (c != '0))
      r = c - CNT_ONE;
    return r;
  endfunction

  assign rd1_idx  = bus.ReadReg1[IW-1:0];
  assign rd2_idx  = bus.ReadReg2[IW-1:0];
  assign wr_idx   = bus.WriteReg[IW-1:0];
  assign iss_idx  = bus.issue_rd[IW-1:0];

  assign rd1_live = live_addr(bus.ReadReg1);
  assign rd2_live = live_addr(bus.ReadReg2);
  assign wr_live  = live_addr(bus.WriteReg);
  assign iss_live = live_addr(bus.issue_rd);

  assign wr_en    = bus.RegWrite && wr_live;
  assign iss_en   = bus.issue_valid && iss_live;

  assign fwd1     = (BYPASS != 0) && wr_en && (bus.WriteReg == bus.ReadReg1);
  assign fwd2     = (BYPASS != 0) && wr_en && (bus.WriteReg == bus.ReadReg2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= bus.D;
    end
  end

  // Read ports are forced to zero while reset is held, even against a forwarded write.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    rbusy1 = 1'b0;
    rbusy2 = 1'b0;
    if (rst && rd1_live) begin
      rdata1 = fwd1 ? bus.D : regs[rd1_idx];
      rbusy1 = busy[rd1_idx] && !fwd1;
    end
    if (rst && rd2_live) begin
      rdata2 = fwd2 ? bus.D : regs[rd2_idx];
      rbusy2 = busy[rd2_idx] && !fwd2;
    end
  end

  assign bus.Read_data1 = rdata1;
  assign bus.Read_data2 = rdata2;
  assign bus.busy1      = rbusy1;
  assign bus.busy2      = rbusy2;

  // Flush beats issue, and a new issue beats a same-cycle writeback clear.
  always_comb begin
    busy_nxt = busy;
    for (int i = 1; i < DEPTH; i++) begin
      if (bus.flush)
        busy_nxt[i] = 1'b0;
      else if (bus.issue_valid && (bus.issue_rd == AW'(i)))
        busy_nxt[i] = 1'b1;
      else if (bus.RegWrite && (bus.WriteReg == AW'(i)))
        busy_nxt[i] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  assign set_evt = iss_en && !busy[iss_idx];
  assign clr_evt = wr_en && busy[wr_idx] &&
                   !(bus.issue_valid && (bus.issue_rd == bus.WriteReg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= count_step(cnt, set_evt, clr_evt);
    end
  end

  assign bus.pending_count = cnt;

endmodule
